// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl
// MEM-stage data-memory controller. Splits one 32-bit load/store into two
// 16-bit accesses on an external asynchronous SRAM. Each half-word beat is
// held on the bus for WAIT_CYCLES cycles. While a transaction is in flight
// `ready` is low, and the pipeline freezes on ~ready.
//
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   wr_en, rd_en      MEM-stage store/load request, held while ready=0
//   address           CPU byte address (word aligned, bits [1:0] ignored)
//   write_data        store data
//   read_data         registered load result, valid from DONE onward
//   ready             0 = stall pipeline; 1 = idle or access completing
//   sram_addr         SRAM half-word address {word, beat}
//   sram_dq_out/oe    write data and its bus-drive enable (tristate built above)
//   sram_dq_in        SRAM bus read value
//   sram_we_n/oe_n    SRAM strobes, active low
//
// state | meaning
// IDLE  | no access; latch a request when wr_en|rd_en
// LOW   | beat 0 (data[15:0]) held for WAIT_CYCLES cycles
// HIGH  | beat 1 (data[31:16]) held for WAIT_CYCLES cycles
// DONE  | one cycle, ready=1, access completes

module sram_access_ctrl #(
    parameter int WAIT_CYCLES = 3,
    parameter int DATA_BASE   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic        sram_oe_n
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [3:0]  CNT_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [31:0] BASE     = 32'(DATA_BASE);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_wr_q, op_wr_d;
    logic [16:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] offset;
    logic        req;
    logic        beat_last;
    logic        beat_d;
    logic        unused_offset_bits;

    logic [31:0] read_data_q;
    logic [17:0] sram_addr_q;
    logic [15:0] sram_dq_out_q;
    logic        sram_dq_oe_q;
    logic        sram_we_n_q;
    logic        sram_oe_n_q;

    assign req       = wr_en | rd_en;
    assign offset    = address - BASE;
    assign beat_last = (cnt_q == CNT_LAST);
    assign beat_d    = (state_d == LOW) || (state_d == HIGH);

    // Only the word index of the offset maps onto the SRAM.
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LOW;
                    cnt_d   = 4'd0;
                    op_wr_d = wr_en;   // store wins when both are requested
                    word_d  = offset[18:2];
                    wdata_d = write_data;
                end
            end
            LOW: begin
                if (beat_last) begin
                    state_d = HIGH;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                if (beat_last) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from next-state values so they switch on the
    // state-entry edge. we_n is released in the last cycle of each beat while
    // data is still driven, giving the SRAM a data hold time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 4'd0;
            op_wr_q       <= 1'b0;
            word_q        <= '0;
            wdata_q       <= '0;
            read_data_q   <= '0;
            sram_addr_q   <= '0;
            sram_dq_out_q <= '0;
            sram_dq_oe_q  <= 1'b0;
            sram_we_n_q   <= 1'b1;
            sram_oe_n_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_wr_q      <= op_wr_d;
            word_q       <= word_d;
            wdata_q      <= wdata_d;
            sram_dq_oe_q <= beat_d && op_wr_d;
            sram_we_n_q  <= !(beat_d && op_wr_d && (cnt_d != CNT_LAST));
            sram_oe_n_q  <= !(beat_d && !op_wr_d);
            if (beat_d) begin
                sram_addr_q   <= {word_d, state_d == HIGH};
                sram_dq_out_q <= (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
            end
            if (!op_wr_q && beat_last) begin
                if (state_q == LOW)  read_data_q[15:0]  <= sram_dq_in;
                if (state_q == HIGH) read_data_q[31:16] <= sram_dq_in;
            end
        end
    end

    assign ready       = !(((state_q == IDLE) && req) || (state_q == LOW) || (state_q == HIGH));
    assign read_data   = read_data_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = sram_dq_out_q;
    assign sram_dq_oe  = sram_dq_oe_q;
    assign sram_we_n   = sram_we_n_q;
    assign sram_oe_n   = sram_oe_n_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl
// Directed bench for sram_access_ctrl with a small asynchronous-SRAM model.
// The model commits a write only when we_n rises while data is still driven,
// so a beat without its hold cycle does not reach the memory.

module tb_sram_access_ctrl;

    localparam int WC   = 3;
    localparam int BASE = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;

    logic [15:0] mem [0:63] = '{default: 16'h0000};
    logic        prev_we_n  = 1'b1;
    logic [5:0]  midx;

    int n_cmp = 0;
    int n_bad = 0;

    sram_access_ctrl #(.WAIT_CYCLES(WC), .DATA_BASE(BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    always #5 clk = ~clk;

    assign midx       = sram_addr[5:0];
    assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[midx];

    always @(negedge clk) begin
        if (sram_we_n && sram_dq_oe && !prev_we_n)
            mem[midx] = sram_dq_out;
        prev_we_n = sram_we_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to the next cycle's midpoint, apply requests, let comb settle.
    task automatic step(input logic w, input logic r);
        @(negedge clk);
        wr_en = w;
        rd_en = r;
        #1;
    endtask

    // One full transaction: request in cycle 0, beats in cycles 1..2*WC,
    // DONE in cycle 2*WC+1, request dropped in the following cycle.
    task automatic do_txn(input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        logic [31:0] ea;
        logic        hi;
        logic        last;
        ea = (a - BASE) >> 2;
        address    = a;
        write_data = d;
        step(w, r);
        check("c0_ready", {31'b0, ready}, 32'd0);
        for (int c = 1; c <= 2 * WC; c++) begin
            step(w, r);
            hi   = (c > WC);
            last = (c == WC) || (c == 2 * WC);
            check($sformatf("c%0d_ready", c), {31'b0, ready}, 32'd0);
            check($sformatf("c%0d_addr", c), {14'b0, sram_addr}, {13'b0, ea[16:0], hi});
            if (w) begin
                check($sformatf("c%0d_dq_oe", c), {31'b0, sram_dq_oe}, 32'd1);
                check($sformatf("c%0d_oe_n", c), {31'b0, sram_oe_n}, 32'd1);
                check($sformatf("c%0d_we_n", c), {31'b0, sram_we_n}, {31'b0, last});
                check($sformatf("c%0d_dq_out", c), {16'b0, sram_dq_out},
                      {16'b0, hi ? d[31:16] : d[15:0]});
            end else begin
                check($sformatf("c%0d_dq_oe", c), {31'b0, sram_dq_oe}, 32'd0);
                check($sformatf("c%0d_oe_n", c), {31'b0, sram_oe_n}, 32'd0);
                check($sformatf("c%0d_we_n", c), {31'b0, sram_we_n}, 32'd1);
            end
        end
        step(w, r);
        check("done_ready", {31'b0, ready}, 32'd1);
        check("done_we_n", {31'b0, sram_we_n}, 32'd1);
        check("done_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check("done_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        check("done_rdata", read_data, exp_rd);
        step(1'b0, 1'b0);
        check("post_ready", {31'b0, ready}, 32'd1);
    endtask

    initial begin
        int pulses;
        rst        = 1'b1;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        address    = '0;
        write_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0);
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        check("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check("rst_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        check("rst_rdata", read_data, 32'd0);
        check("rst_addr", {14'b0, sram_addr}, 32'd0);
        check("rst_dq_out", {16'b0, sram_dq_out}, 32'd0);

        // Store 0xDEADBEEF at 1024+8 -> half-words 4 and 5.
        do_txn(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF, 32'd0);
        check("st_mem4", {16'b0, mem[4]}, 32'h0000BEEF);
        check("st_mem5", {16'b0, mem[5]}, 32'h0000DEAD);

        // Load it back.
        do_txn(1'b0, 1'b1, 32'd1032, 32'h0, 32'hDEADBEEF);

        // Both requests: store wins, read_data untouched.
        do_txn(1'b1, 1'b1, 32'd1040, 32'h12345678, 32'hDEADBEEF);
        check("both_mem8", {16'b0, mem[8]}, 32'h00005678);
        check("both_mem9", {16'b0, mem[9]}, 32'h00001234);

        // Reset during cycle 4 of a store to 1024+24 (half-words 12, 13).
        address    = 32'd1048;
        write_data = 32'hCAFEF00D;
        step(1'b1, 1'b0);
        for (int c = 1; c <= 4; c++) step(1'b1, 1'b0);
        check("rs_c4_addr", {14'b0, sram_addr}, 32'd13);
        check("rs_c4_we_n", {31'b0, sram_we_n}, 32'd0);
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
        check("rs_ready", {31'b0, ready}, 32'd1);
        check("rs_we_n", {31'b0, sram_we_n}, 32'd1);
        check("rs_oe_n", {31'b0, sram_oe_n}, 32'd1);
        check("rs_dq_oe", {31'b0, sram_dq_oe}, 32'd0);
        check("rs_rdata", read_data, 32'd0);
        step(1'b0, 1'b0);
        check("rs_idle_ready", {31'b0, ready}, 32'd1);
        check("rs_idle_we_n", {31'b0, sram_we_n}, 32'd1);
        check("rs_mem12", {16'b0, mem[12]}, 32'h0000F00D);
        check("rs_mem13", {16'b0, mem[13]}, 32'h00000000);

        // Back-to-back load (1024+16) then store (1024+32) on a frozen pipeline.
        pulses = 0;
        for (int c = 0; c < 16; c++) begin
            address    = (c < 8) ? 32'd1040 : 32'd1056;
            write_data = 32'h0BADF00D;
            step(c >= 8, c < 8);
            if (ready) pulses++;
            if (c == 7) begin
                check("b2b_c7_ready", {31'b0, ready}, 32'd1);
                check("b2b_c7_rdata", read_data, 32'h12345678);
            end
            if (c == 8) check("b2b_c8_ready", {31'b0, ready}, 32'd0);
            if (c == 15) check("b2b_c15_ready", {31'b0, ready}, 32'd1);
        end
        step(1'b0, 1'b0);
        check("b2b_pulses", pulses, 32'd2);
        check("b2b_mem16", {16'b0, mem[16]}, 32'h0000F00D);
        check("b2b_mem17", {16'b0, mem[17]}, 32'h00000BAD);
        check("b2b_rdata", read_data, 32'h12345678);
        check("b2b_idle_ready", {31'b0, ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Memory-stage data-memory controller. It drives the `ready` signal; the pipeline derives `freeze = ~ready`, which stalls the IF/ID/EXE/MEM pipeline registers.
- Converts one 32-bit MEM-stage load/store into two 16-bit accesses on an external asynchronous SRAM.
- Each half-word access is held for a programmable number of wait cycles.
- Sits between the MEM stage and the board SRAM pins.

Parameters:
WAIT_CYCLES, 3, cycles each 16-bit beat is held on the SRAM bus (legal range 1..15)
DATA_BASE, 1024, byte address subtracted from the CPU address before mapping to SRAM

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
wr_en  input  1  MEM-stage store request, held while ready=0
rd_en  input  1  MEM-stage load request, held while ready=0
address  input  32  byte address from the EXE result, word aligned
write_data  input  32  store data (Rm value)
read_data  output  32  load result, registered
ready  output  1  0 = stall the pipeline; 1 = the access completes this cycle, or the controller is idle
sram_addr  output  18  SRAM half-word address
sram_dq_out  output  16  write data driven onto the SRAM bus
sram_dq_oe  output  1  1 = drive sram_dq_out onto the bus (the top level builds the tristate)
sram_dq_in  input  16  SRAM bus read value
sram_we_n  output  1  SRAM write enable, active low
sram_oe_n  output  1  SRAM output enable, active low

Behaviour:
- Reset (sync, rst=1 at posedge):
  - state=IDLE, wait counter=0, read_data=0.
  - sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - ready=1 after reset is released.
  - Reset mid-transaction aborts it immediately. No further SRAM strobes are issued, and read_data is not updated.
- Address mapping:
  - word = (address - DATA_BASE)[18:2], computed as a 32-bit subtract.
  - sram_addr = {word[16:0], beat}, where beat=0 selects the low half and beat=1 the high half.
  - Address bits [1:0] are ignored.
- States: IDLE, LOW, HIGH, DONE.
  - IDLE: if wr_en|rd_en, latch the operation (write has priority when both are set), address and write_data; go to LOW. Otherwise stay in IDLE.
  - LOW: beat 0 is presented. Stay WAIT_CYCLES cycles, then go to HIGH.
  - HIGH: beat 1 is presented. Stay WAIT_CYCLES cycles, then go to DONE.
  - DONE: one cycle, then IDLE.
- ready (combinational):
  - ready = 0 in IDLE when wr_en|rd_en=1, and in LOW and HIGH.
  - ready = 1 in DONE, and in IDLE with no request.
- Latency: a request first seen in cycle 0 gives ready=0 for cycles 0..2*WAIT_CYCLES and ready=1 in cycle 2*WAIT_CYCLES+1. For WAIT_CYCLES=3, ready is low for 7 cycles.
- Strobes: outputs are registered from the next-state logic, so they change on the state-entry edge.
  - Write, in LOW/HIGH:
    - sram_dq_oe=1, sram_oe_n=1.
    - sram_dq_out = latched data[15:0] in LOW, [31:16] in HIGH.
    - sram_we_n=0 in every beat cycle except the last cycle of each beat, where it is 1. This gives a data hold time.
  - Read, in LOW/HIGH: sram_oe_n=0, sram_dq_oe=0, sram_we_n=1.
  - IDLE/DONE: all strobes inactive.
- Read capture:
  - read_data[15:0] <= sram_dq_in on the last cycle of LOW.
  - read_data[31:16] <= sram_dq_in on the last cycle of HIGH.
  - read_data is therefore valid in DONE and held until the next read completes. Writes never change read_data.
- Request dropped mid-transaction (wr_en/rd_en falls in LOW/HIGH): the transaction still completes fully, so a store is never torn, and DONE is still entered.
- Request still asserted in DONE: treated as the same access completing. The FSM returns to IDLE, and a request present in the IDLE cycle after DONE starts a new transaction.
- Wait counter: 4 bits, reset to 0 on entry to each beat. It counts 0..WAIT_CYCLES-1 and never wraps within a beat.

Test Plan:
- Reset then idle, no request -> ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, read_data=0.
- Store address=1024+8, write_data=0xDEADBEEF, WAIT_CYCLES=3:
  - Cycles 1-3: sram_addr=0x00004, dq_out=0xBEEF, we_n low in cycles 1-2.
  - Cycles 4-6: sram_addr=0x00005, dq_out=0xDEAD.
  - ready=1 only in cycle 7.
- Load address=1024+8 with the SRAM model returning that data -> read_data=0xDEADBEEF in cycle 7, oe_n=0 in cycles 1-6, sram_dq_oe never set.
- wr_en and rd_en both set -> write performed, read_data unchanged.
- rst asserted in cycle 4 of a store -> the next cycle is IDLE with all strobes inactive, ready=1 with no request, and the high half is not written.
- Back-to-back load then store held by a frozen pipeline -> two 8-cycle transactions with an IDLE cycle between them, and exactly 2 ready pulses.
